// File: rtl/grant_hold_ctrl.sv
// grant_hold_ctrl: holds a one-hot grant for one tenure. A tenure is bounded by a
// beat budget (MAX_BEATS), by the granted requester dropping its request, or,
// when the macro GRANT_TIMEOUT_EN is defined, by a watchdog that expires after
// TIMEOUT_CYC BUSY cycles without a done beat.
// The grant register keeps the last winner across REL/IDLE so the upstream
// rotation has a stable pointer. Only reset clears it.
module grant_hold_ctrl #(
  parameter int unsigned CHANNELS    = 8,
  parameter int unsigned MAX_BEATS   = 4,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] req,
  input  logic [CHANNELS-1:0] next_grant,
  input  logic                done,
  output logic [CHANNELS-1:0] grant,
  output logic                grant_valid,
  output logic [3:0]          beat_cnt,
  output logic                rel,
  output logic                timeout
);

  localparam int unsigned BEAT_W = 4;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BEATS - 1);

  // Reject out-of-range configurations at elaboration time
  if (MAX_BEATS == 0 || MAX_BEATS > 15) begin : g_bad_max_beats
    $error("grant_hold_ctrl: MAX_BEATS must be within 1..15");
  end
  if (TIMEOUT_CYC == 0 || TIMEOUT_CYC > 255) begin : g_bad_timeout_cyc
    $error("grant_hold_ctrl: TIMEOUT_CYC must be within 1..255");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_REL  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CHANNELS-1:0] grant_q, grant_d;
  logic                grant_valid_q, grant_valid_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic                rel_q, rel_d;
  logic                req_lost_c;
  logic                beats_spent_c;

`ifdef GRANT_TIMEOUT_EN
  localparam int unsigned WD_W = 8;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            timeout_q, timeout_d;
  logic            wdog_expire_c;
`endif

  // Isolate the lowest set bit, which keeps the loaded grant one-hot
  function automatic logic [CHANNELS-1:0] lowest_set(input logic [CHANNELS-1:0] v);
    return v & (~v + CHANNELS'(1));
  endfunction

  // Release conditions evaluated against the held grant
  always_comb begin
    req_lost_c    = ((req & grant_q) == '0);
    beats_spent_c = done && (beat_cnt_q == LAST_BEAT);
  end

`ifdef GRANT_TIMEOUT_EN
  // Watchdog expires when the idle-beat count reaches its limit with no done this cycle
  always_comb begin
    wdog_expire_c = (state_q == S_BUSY) && !done && (wdog_q == WD_LAST);
  end
`endif

  // Next-state and registered-output computation
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_valid_d = 1'b0;
    beat_cnt_d    = beat_cnt_q;
    rel_d         = 1'b0;
`ifdef GRANT_TIMEOUT_EN
    wdog_d        = wdog_q;
    timeout_d     = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        beat_cnt_d = '0;
        if (next_grant != '0) begin
          state_d       = S_BUSY;
          grant_d       = lowest_set(next_grant);
          grant_valid_d = 1'b1;
`ifdef GRANT_TIMEOUT_EN
          wdog_d        = '0;
`endif
        end
      end

      S_BUSY: begin
        grant_valid_d = 1'b1;
        // A beat landing in the release cycle is still recorded
        if (done) begin
          beat_cnt_d = beat_cnt_q + BEAT_W'(1);
        end
`ifdef GRANT_TIMEOUT_EN
        wdog_d = done ? '0 : wdog_q + WD_W'(1);
        if (beats_spent_c || req_lost_c || wdog_expire_c) begin
          state_d       = S_REL;
          grant_valid_d = 1'b0;
          rel_d         = 1'b1;
          timeout_d     = wdog_expire_c;
          wdog_d        = '0;
        end
`else
        if (beats_spent_c || req_lost_c) begin
          state_d       = S_REL;
          grant_valid_d = 1'b0;
          rel_d         = 1'b1;
        end
`endif
      end

      S_REL: begin
        state_d    = S_IDLE;
        beat_cnt_d = '0;
      end

      default: begin
        state_d    = S_IDLE;
        beat_cnt_d = '0;
      end
    endcase
  end

  // State and output registers; reset aborts any tenure silently
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      beat_cnt_q    <= '0;
      rel_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      beat_cnt_q    <= beat_cnt_d;
      rel_q         <= rel_d;
    end
  end

`ifdef GRANT_TIMEOUT_EN
  // Watchdog counter and timeout pulse registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign beat_cnt    = beat_cnt_q;
  assign rel         = rel_q;

endmodule

// File: tb/tb_grant_hold_ctrl.sv
// Directed bench for grant_hold_ctrl with default parameters.
// Expectations for the watchdog case follow GRANT_TIMEOUT_EN as compiled.
module tb_grant_hold_ctrl;

  localparam int unsigned CHANNELS = 8;

  logic                clk;
  logic                reset;
  logic [CHANNELS-1:0] req;
  logic [CHANNELS-1:0] next_grant;
  logic                done;
  logic [CHANNELS-1:0] grant;
  logic                grant_valid;
  logic [3:0]          beat_cnt;
  logic                rel;
  logic                timeout;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  grant_hold_ctrl #(
    .CHANNELS   (8),
    .MAX_BEATS  (4),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .next_grant (next_grant),
    .done       (done),
    .grant      (grant),
    .grant_valid(grant_valid),
    .beat_cnt   (beat_cnt),
    .rel        (rel),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one active edge and land on the following falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_outs(input string tag, input logic [7:0] g, input logic gv,
                            input logic [3:0] bc, input logic r, input logic to);
    check({tag, ".grant"}, 32'(grant), 32'(g));
    check({tag, ".grant_valid"}, 32'(grant_valid), 32'(gv));
    check({tag, ".beat_cnt"}, 32'(beat_cnt), 32'(bc));
    check({tag, ".rel"}, 32'(rel), 32'(r));
    check({tag, ".timeout"}, 32'(timeout), 32'(to));
  endtask

  initial begin
    reset      = 1'b0;
    req        = '0;
    next_grant = '0;
    done       = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_outs("reset", 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
    reset = 1'b1;

    // Idle with nothing offered holds grant at zero
    step();
    check_outs("idle0", 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);

    // Multi-hot candidate: lowest index wins
    req        = 8'b0110_1000;
    next_grant = 8'b0110_1000;
    step();
    check_outs("load08", 8'h08, 1'b1, 4'd0, 1'b0, 1'b0);

    // Four consecutive beats exhaust the budget
    next_grant = '0;
    done       = 1'b1;
    step();
    check_outs("beat1", 8'h08, 1'b1, 4'd1, 1'b0, 1'b0);
    step();
    check_outs("beat2", 8'h08, 1'b1, 4'd2, 1'b0, 1'b0);
    step();
    check_outs("beat3", 8'h08, 1'b1, 4'd3, 1'b0, 1'b0);
    step();
    check("max.rel", 32'(rel), 32'd1);
    check("max.grant_valid", 32'(grant_valid), 32'd0);
    check("max.grant", 32'(grant), 32'h08);
    done = 1'b0;
    step();
    check_outs("max.idle", 8'h08, 1'b0, 4'd0, 1'b0, 1'b0);
    step();
    check_outs("hold08", 8'h08, 1'b0, 4'd0, 1'b0, 1'b0);

    // Request drop with a coincident beat: beat counted, single release
    req        = 8'h01;
    next_grant = 8'h01;
    step();
    check_outs("load01", 8'h01, 1'b1, 4'd0, 1'b0, 1'b0);
    next_grant = '0;
    done       = 1'b1;
    step();
    check_outs("drop.b1", 8'h01, 1'b1, 4'd1, 1'b0, 1'b0);
    req = '0;
    step();
    check_outs("drop.rel", 8'h01, 1'b0, 4'd2, 1'b1, 1'b0);
    done = 1'b0;
    step();
    check_outs("drop.idle", 8'h01, 1'b0, 4'd0, 1'b0, 1'b0);
    step();
    check_outs("drop.once", 8'h01, 1'b0, 4'd0, 1'b0, 1'b0);

    // next_grant ignored while BUSY and in REL
    req        = 8'h10;
    next_grant = 8'h30;
    step();
    check_outs("load10", 8'h10, 1'b1, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      next_grant = (i % 2 == 0) ? 8'h03 : 8'h40;
      step();
      check("busy.hold", 32'(grant), 32'h10);
    end
    req        = '0;
    next_grant = 8'h02;
    step();
    check_outs("ign.rel", 8'h10, 1'b0, 4'd0, 1'b1, 1'b0);
    next_grant = '0;
    step();
    check_outs("ign.idle", 8'h10, 1'b0, 4'd0, 1'b0, 1'b0);

    // Watchdog: no done for a long stretch
    req        = 8'h80;
    next_grant = 8'h80;
    step();
    check_outs("load80", 8'h80, 1'b1, 4'd0, 1'b0, 1'b0);
    next_grant = '0;
    for (int i = 1; i < 16; i++) begin
      step();
    end
    check_outs("wd.pre", 8'h80, 1'b1, 4'd0, 1'b0, 1'b0);
    step();
`ifdef GRANT_TIMEOUT_EN
    check_outs("wd.fire", 8'h80, 1'b0, 4'd0, 1'b1, 1'b1);
    step();
    check_outs("wd.idle", 8'h80, 1'b0, 4'd0, 1'b0, 1'b0);
`else
    check_outs("wd.none", 8'h80, 1'b1, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step();
    end
    check_outs("wd.stay", 8'h80, 1'b1, 4'd0, 1'b0, 1'b0);
`endif

    // Asynchronous reset mid-tenure with grant 04
    reset = 1'b0;
    #2;
    reset = 1'b1;
    req        = 8'h04;
    next_grant = 8'h04;
    step();
    check_outs("load04", 8'h04, 1'b1, 4'd0, 1'b0, 1'b0);
    next_grant = '0;
    done       = 1'b1;
    step();
    check_outs("r04.b1", 8'h04, 1'b1, 4'd1, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_outs("async", 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
    done = 1'b0;
    step();
    check_outs("rst.hold", 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    check_outs("rst.norel", 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);

    // First tenure after reset starts from IDLE
    req        = 8'h06;
    next_grant = 8'h06;
    step();
    check_outs("post.load", 8'h02, 1'b1, 4'd0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
